// File: rtl/display_frame_integrator.sv
// Integrates NB_FRAMES garbled display frames into per-pixel hit counters,
// then streams out the thresholded bitmap one row per handshake.
module display_frame_integrator #(
  parameter int WIDTH     = 120,
  parameter int HEIGHT    = 52,
  parameter int NB_FRAMES = 16,
  parameter int THRESHOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row,
  output logic             out_last,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(NB_FRAMES + 1);
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FRM_W = (NB_FRAMES > 1) ? $clog2(NB_FRAMES) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NB_FRAMES - 1);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t           state, state_n;
  logic [ROW_W-1:0] row_idx, row_idx_n;
  logic [ROW_W-1:0] out_idx, out_idx_n;
  logic [FRM_W-1:0] frame_idx, frame_idx_n;
  logic             frame_err_n;
  logic             accept;
  logic [CNT_W-1:0] cnt [HEIGHT][WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      row_idx   <= '0;
      out_idx   <= '0;
      frame_idx <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      row_idx   <= row_idx_n;
      out_idx   <= out_idx_n;
      frame_idx <= frame_idx_n;
      frame_err <= frame_err_n;
    end
  end

  // A missing in_last still closes the frame; an early one restarts the whole integration.
  always_comb begin
    state_n     = state;
    row_idx_n   = row_idx;
    out_idx_n   = out_idx;
    frame_idx_n = frame_idx;
    frame_err_n = 1'b0;
    in_ready    = (state == ACCUM) && !rst;
    out_valid   = (state == EMIT);
    out_last    = (state == EMIT) && (out_idx == ROW_LAST);
    accept      = in_valid && in_ready;

    if (accept) begin
      if (row_idx == ROW_LAST) begin
        row_idx_n   = '0;
        frame_err_n = !in_last;
        if (frame_idx == FRM_LAST) begin
          frame_idx_n = '0;
          state_n     = EMIT;
        end else begin
          frame_idx_n = frame_idx + 1'b1;
        end
      end else if (in_last) begin
        row_idx_n   = '0;
        frame_idx_n = '0;
        frame_err_n = 1'b1;
      end else begin
        row_idx_n = row_idx + 1'b1;
      end
    end

    if ((state == EMIT) && out_ready) begin
      if (out_idx == ROW_LAST) begin
        out_idx_n   = '0;
        frame_idx_n = '0;
        state_n     = ACCUM;
      end else begin
        out_idx_n = out_idx + 1'b1;
      end
    end
  end

  // Counters carry no reset: frame 0 overwrites whatever a previous integration left.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int x = 0; x < WIDTH; x++) begin
        cnt[row_idx][x] <= (frame_idx == '0) ? CNT_W'(in_row[x])
                                             : cnt[row_idx][x] + CNT_W'(in_row[x]);
      end
    end
  end

  always_comb begin
    out_row = '0;
    if (state == EMIT) begin
      for (int x = 0; x < WIDTH; x++) begin
        out_row[x] = (cnt[out_idx][x] >= THR);
      end
    end
  end

endmodule
